// File: rtl/obj_stepper.sv
// -----------------------------------------------------------------------------
// obj_stepper
// Moves N_OBJ objects on a bounded 2-D grid. Each object has an integer
// position, a signed Q.16 sub-pixel remainder and a signed Q.16 speed on each
// axis. A step request runs one pass that updates one object per clock. An
// axis that would leave its bounds is clamped to the bound, and its remainder
// and speed on that axis are zeroed.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   step_i                       start one movement pass (ignored while busy)
//   wr_en_i, wr_idx_i,
//   wr_pos_x_i/wr_pos_y_i,
//   wr_spd_x_i/wr_spd_y_i        load one object (accepted only when idle)
//   wr_ack_o                     write accepted this cycle
//   rd_idx_i                     combinational read select
//   rd_pos_x_o/rd_pos_y_o,
//   rd_rem_x_o/rd_rem_y_o,
//   rd_spd_x_o/rd_spd_y_o,
//   rd_hit_o                     read data, rd_hit_o = {y_clamped, x_clamped}
//   busy_o, done_o               pass in progress / one-cycle pass-complete
//   ovr_o, ovr_clr_i             sticky "step while busy" flag and its clear
// -----------------------------------------------------------------------------
module obj_stepper #(
   parameter int N_OBJ = 4,
   parameter int POS_W = 16,
   parameter int FX_W  = 32,
   parameter int X_MIN = 0,
   parameter int X_MAX = 127,
   parameter int Y_MIN = 0,
   parameter int Y_MAX = 127,
   parameter int RST_X = 8,
   parameter int RST_Y = 96,
   localparam int IW   = $clog2(N_OBJ)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    step_i,
   input  logic                    wr_en_i,
   input  logic [IW-1:0]           wr_idx_i,
   input  logic [POS_W-1:0]        wr_pos_x_i,
   input  logic [POS_W-1:0]        wr_pos_y_i,
   input  logic [FX_W-1:0]         wr_spd_x_i,
   input  logic [FX_W-1:0]         wr_spd_y_i,
   output logic                    wr_ack_o,
   input  logic [IW-1:0]           rd_idx_i,
   output logic [POS_W-1:0]        rd_pos_x_o,
   output logic [POS_W-1:0]        rd_pos_y_o,
   output logic [FX_W-1:0]         rd_rem_x_o,
   output logic [FX_W-1:0]         rd_rem_y_o,
   output logic [FX_W-1:0]         rd_spd_x_o,
   output logic [FX_W-1:0]         rd_spd_y_o,
   output logic [1:0]              rd_hit_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    ovr_o,
   input  logic                    ovr_clr_i
);

   // Width of the position sum: integer position plus integer part of a move.
   localparam int PW  = POS_W + FX_W - 16 + 1;
   localparam int AXW = POS_W + FX_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          ovr_q, ovr_d;

   logic [POS_W-1:0] pos_x_q [N_OBJ];
   logic [POS_W-1:0] pos_y_q [N_OBJ];
   logic [FX_W-1:0]  rem_x_q [N_OBJ];
   logic [FX_W-1:0]  rem_y_q [N_OBJ];
   logic [FX_W-1:0]  spd_x_q [N_OBJ];
   logic [FX_W-1:0]  spd_y_q [N_OBJ];
   logic [1:0]       hit_q   [N_OBJ];

   logic             wr_ok_s;
   logic             last_s;
   logic [AXW-1:0]   ax_x_s;
   logic [AXW-1:0]   ax_y_s;

   // One axis update. Returns {hit, new_pos, new_rem}; on hit the position is
   // the violated bound and the remainder is zero (caller zeroes speed).
   function automatic logic [AXW-1:0] axis_step(
      input logic signed [POS_W-1:0] pos,
      input logic signed [FX_W-1:0]  rem,
      input logic signed [FX_W-1:0]  spd,
      input int                      mn,
      input int                      mx
   );
      logic signed [FX_W-1:0] r;
      logic signed [FX_W:0]   rr;
      logic signed [FX_W:0]   amt;
      logic signed [FX_W-1:0] rem_n;
      logic signed [PW-1:0]   p;
      logic signed [PW-1:0]   lo;
      logic signed [PW-1:0]   hi;
      r     = rem + spd;
      // Add one half and floor: round-half-up to the nearest integer step.
      rr    = (FX_W+1)'(r) + (FX_W+1)'(32'sh0000_8000);
      amt   = rr >>> 16;
      rem_n = r - FX_W'(amt <<< 16);
      p     = PW'(pos) + PW'(amt);
      lo    = PW'(mn);
      hi    = PW'(mx);
      if (p < lo) begin
         axis_step = {1'b1, lo[POS_W-1:0], {FX_W{1'b0}}};
      end else if (p > hi) begin
         axis_step = {1'b1, hi[POS_W-1:0], {FX_W{1'b0}}};
      end else begin
         axis_step = {1'b0, p[POS_W-1:0], rem_n};
      end
   endfunction

   // Index decode helpers for the write port and the last object of a pass.
   always_comb begin
      wr_ok_s = (32'(wr_idx_i) < N_OBJ);
      last_s  = (idx_q == IW'(N_OBJ - 1));
   end

   // FSM state, pass index and overrun flag registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= {IW{1'b0}};
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ovr_q   <= ovr_d;
      end
   end

   // Next-state logic for the FSM, pass index and overrun flag.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (step_i) begin
               state_d = S_RUN;
               idx_d   = {IW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (last_s) begin
               state_d = S_DONE;
               idx_d   = {IW{1'b0}};
            end else begin
               idx_d   = idx_q + IW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = {IW{1'b0}};
         end
      endcase
      // A step while busy is dropped but remembered; set beats clear.
      if (step_i && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end else if (ovr_clr_i) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // FSM outputs and write handshake.
   always_comb begin
      busy_o   = (state_q != S_IDLE);
      done_o   = (state_q == S_DONE);
      ovr_o    = ovr_q;
      wr_ack_o = wr_en_i && (state_q == S_IDLE) && wr_ok_s;
   end

   // Update of the object selected by the pass index, both axes at once.
   always_comb begin
      ax_x_s = axis_step(pos_x_q[idx_q], rem_x_q[idx_q], spd_x_q[idx_q], X_MIN, X_MAX);
      ax_y_s = axis_step(pos_y_q[idx_q], rem_y_q[idx_q], spd_y_q[idx_q], Y_MIN, Y_MAX);
   end

   // Object state storage: reset, host write when idle, pass update in RUN.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N_OBJ; i++) begin
            pos_x_q[i] <= POS_W'(RST_X);
            pos_y_q[i] <= POS_W'(RST_Y);
            rem_x_q[i] <= {FX_W{1'b0}};
            rem_y_q[i] <= {FX_W{1'b0}};
            spd_x_q[i] <= {FX_W{1'b0}};
            spd_y_q[i] <= {FX_W{1'b0}};
            hit_q[i]   <= 2'b00;
         end
      end else begin
         for (int i = 0; i < N_OBJ; i++) begin
            if (wr_ack_o && (wr_idx_i == IW'(i))) begin
               pos_x_q[i] <= wr_pos_x_i;
               pos_y_q[i] <= wr_pos_y_i;
               rem_x_q[i] <= {FX_W{1'b0}};
               rem_y_q[i] <= {FX_W{1'b0}};
               spd_x_q[i] <= wr_spd_x_i;
               spd_y_q[i] <= wr_spd_y_i;
               hit_q[i]   <= 2'b00;
            end else if ((state_q == S_RUN) && (idx_q == IW'(i))) begin
               pos_x_q[i] <= ax_x_s[POS_W+FX_W-1:FX_W];
               rem_x_q[i] <= ax_x_s[FX_W-1:0];
               pos_y_q[i] <= ax_y_s[POS_W+FX_W-1:FX_W];
               rem_y_q[i] <= ax_y_s[FX_W-1:0];
               if (ax_x_s[AXW-1]) begin
                  spd_x_q[i] <= {FX_W{1'b0}};
               end
               if (ax_y_s[AXW-1]) begin
                  spd_y_q[i] <= {FX_W{1'b0}};
               end
               hit_q[i]   <= {ax_y_s[AXW-1], ax_x_s[AXW-1]};
            end
         end
      end
   end

   // Combinational read port; out-of-range indices read as zero.
   always_comb begin
      if (32'(rd_idx_i) < N_OBJ) begin
         rd_pos_x_o = pos_x_q[rd_idx_i];
         rd_pos_y_o = pos_y_q[rd_idx_i];
         rd_rem_x_o = rem_x_q[rd_idx_i];
         rd_rem_y_o = rem_y_q[rd_idx_i];
         rd_spd_x_o = spd_x_q[rd_idx_i];
         rd_spd_y_o = spd_y_q[rd_idx_i];
         rd_hit_o   = hit_q[rd_idx_i];
      end else begin
         rd_pos_x_o = {POS_W{1'b0}};
         rd_pos_y_o = {POS_W{1'b0}};
         rd_rem_x_o = {FX_W{1'b0}};
         rd_rem_y_o = {FX_W{1'b0}};
         rd_spd_x_o = {FX_W{1'b0}};
         rd_spd_y_o = {FX_W{1'b0}};
         rd_hit_o   = 2'b00;
      end
   end

endmodule

// File: tb/tb_obj_stepper.sv
module tb_obj_stepper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        step = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_idx = 2'd0;
   logic [15:0] wr_pos_x = 16'd0, wr_pos_y = 16'd0;
   logic [31:0] wr_spd_x = 32'd0, wr_spd_y = 32'd0;
   logic        wr_ack;
   logic [1:0]  rd_idx = 2'd0;
   logic [15:0] rd_pos_x, rd_pos_y;
   logic [31:0] rd_rem_x, rd_rem_y, rd_spd_x, rd_spd_y;
   logic [1:0]  rd_hit;
   logic        busy, done, ovr;
   logic        ovr_clr = 1'b0;

   int vectors = 0;
   int miss = 0;

   obj_stepper dut (
      .clk_i(clk), .rst_i(rst), .step_i(step),
      .wr_en_i(wr_en), .wr_idx_i(wr_idx),
      .wr_pos_x_i(wr_pos_x), .wr_pos_y_i(wr_pos_y),
      .wr_spd_x_i(wr_spd_x), .wr_spd_y_i(wr_spd_y),
      .wr_ack_o(wr_ack), .rd_idx_i(rd_idx),
      .rd_pos_x_o(rd_pos_x), .rd_pos_y_o(rd_pos_y),
      .rd_rem_x_o(rd_rem_x), .rd_rem_y_o(rd_rem_y),
      .rd_spd_x_o(rd_spd_x), .rd_spd_y_o(rd_spd_y),
      .rd_hit_o(rd_hit), .busy_o(busy), .done_o(done),
      .ovr_o(ovr), .ovr_clr_i(ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] i, input logic [15:0] px, input logic [15:0] py,
                     input logic [31:0] sx, input logic [31:0] sy);
      wr_en = 1'b1; wr_idx = i;
      wr_pos_x = px; wr_pos_y = py; wr_spd_x = sx; wr_spd_y = sy;
      #1;
      chk("wr_ack_idle", 64'(wr_ack), 64'd1);
      tick();
      wr_en = 1'b0;
   endtask

   // Counts edges from the current point until done is seen (bounded).
   task automatic wait_done(input string tag, input int start, input int exp_lat);
      int n;
      n = start;
      while (!done && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
      tick();
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic run_pass(input string tag);
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_done(tag, 1, 5);
   endtask

   task automatic chk_obj(input string tag, input logic [1:0] i,
                          input logic [15:0] px, input logic [15:0] py,
                          input logic [31:0] rx, input logic [31:0] ry,
                          input logic [31:0] sx, input logic [31:0] sy,
                          input logic [1:0] h);
      rd_idx = i;
      #1;
      chk({tag, "_pos_x"}, 64'(rd_pos_x), 64'(px));
      chk({tag, "_pos_y"}, 64'(rd_pos_y), 64'(py));
      chk({tag, "_rem_x"}, 64'(rd_rem_x), 64'(rx));
      chk({tag, "_rem_y"}, 64'(rd_rem_y), 64'(ry));
      chk({tag, "_spd_x"}, 64'(rd_spd_x), 64'(sx));
      chk({tag, "_spd_y"}, 64'(rd_spd_y), 64'(sy));
      chk({tag, "_hit"},   64'(rd_hit),   64'(h));
   endtask

   initial begin
      int pulses;

      // Reset state.
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ovr",  64'(ovr),  64'd0);
      for (int i = 0; i < 4; i++)
         chk_obj("rst_obj", 2'(i), 16'd8, 16'd96, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Fractional motion: +1.5 on x, -0.5 on y.
      wr(2'd0, 16'd8, 16'd96, 32'h0001_8000, 32'hFFFF_8000);
      run_pass("p1");
      chk_obj("p1_obj0", 2'd0, 16'd10, 16'd96, 32'hFFFF_8000, 32'hFFFF_8000,
              32'h0001_8000, 32'hFFFF_8000, 2'b00);
      chk_obj("p1_obj1", 2'd1, 16'd8, 16'd96, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);
      run_pass("p2");
      chk_obj("p2_obj0", 2'd0, 16'd11, 16'd95, 32'd0, 32'd0,
              32'h0001_8000, 32'hFFFF_8000, 2'b00);

      // Clamp at X_MAX, then move back in; clamp at Y_MIN on another object.
      wr(2'd1, 16'd126, 16'd50, 32'h0003_0000, 32'd0);
      run_pass("clx");
      chk_obj("clx_obj1", 2'd1, 16'd127, 16'd50, 32'd0, 32'd0, 32'd0, 32'd0, 2'b01);
      chk_obj("clx_obj2", 2'd2, 16'd8, 16'd96, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);
      wr(2'd1, 16'd127, 16'd50, 32'hFFFF_0000, 32'd0);
      wr(2'd2, 16'd5, 16'd1, 32'd0, 32'hFFFD_0000);
      run_pass("back");
      chk_obj("back_obj1", 2'd1, 16'd126, 16'd50, 32'd0, 32'd0, 32'hFFFF_0000, 32'd0, 2'b00);
      chk_obj("cly_obj2", 2'd2, 16'd5, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b10);

      // Step held for three cycles: a single pass and a sticky overrun.
      step = 1'b1;
      tick(); tick(); tick();
      step = 1'b0;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         if (done) pulses++;
         tick();
      end
      chk("hold_done_pulses", 64'(pulses), 64'd1);
      chk("hold_ovr", 64'(ovr), 64'd1);
      chk("hold_busy", 64'(busy), 64'd0);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clr", 64'(ovr), 64'd0);

      // Write while busy is ignored; step+clear while busy leaves ovr set.
      wr(2'd3, 16'd20, 16'd20, 32'd0, 32'd0);
      step = 1'b1;
      tick();
      step = 1'b0;
      wr_en = 1'b1; wr_idx = 2'd3; wr_pos_x = 16'd60; wr_pos_y = 16'd60;
      wr_spd_x = 32'h0001_0000; wr_spd_y = 32'h0001_0000;
      #1;
      chk("wr_ack_busy", 64'(wr_ack), 64'd0);
      step = 1'b1; ovr_clr = 1'b1;
      tick();
      wr_en = 1'b0; step = 1'b0; ovr_clr = 1'b0;
      chk("ovr_set_wins", 64'(ovr), 64'd1);
      wait_done("busywr", 2, 5);
      chk_obj("busywr_obj3", 2'd3, 16'd20, 16'd20, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;

      // Step and write in the same idle cycle: pass uses the written values.
      wr_en = 1'b1; wr_idx = 2'd3; wr_pos_x = 16'd30; wr_pos_y = 16'd40;
      wr_spd_x = 32'h0001_0000; wr_spd_y = 32'd0;
      step = 1'b1;
      #1;
      chk("wr_ack_step", 64'(wr_ack), 64'd1);
      tick();
      wr_en = 1'b0; step = 1'b0;
      wait_done("stepwr", 1, 5);
      chk_obj("stepwr_obj3", 2'd3, 16'd31, 16'd40, 32'd0, 32'd0, 32'h0001_0000, 32'd0, 2'b00);

      // Reset in the middle of a pass (idx = 2).
      step = 1'b1;
      tick();
      step = 1'b0;
      tick(); tick();
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      for (int i = 0; i < 4; i++)
         chk_obj("midrst_obj", 2'(i), 16'd8, 16'd96, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);
      #1;
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done) pulses++;
      end
      chk("midrst_no_done", 64'(pulses), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end

endmodule

// File: doc/obj_stepper.md
OBJ_STEPPER -- requirements
Module: obj_stepper

Interface
REQ-001 SHALL have parameter N_OBJ, 4, number of objects (2..16).
REQ-002 SHALL have parameter POS_W, 16, signed integer position width.
REQ-003 SHALL have parameter FX_W, 32, signed Q(FX_W-16).16 width for rem and spd.
REQ-004 SHALL have parameters X_MIN/X_MAX/Y_MIN/Y_MAX, 0/127/0/127, inclusive position bounds.
REQ-005 SHALL have parameters RST_X/RST_Y, 8/96, reset position of every object.
REQ-006 SHALL have one clock and one reset: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have step  in  1  start one movement pass over all objects.
REQ-008 SHALL have wr_en  in  1, wr_idx  in  clog2(N_OBJ), wr_pos_x/wr_pos_y  in  POS_W, wr_spd_x/wr_spd_y  in  FX_W; load one object.
REQ-009 SHALL have wr_ack  out  1  write accepted this cycle.
REQ-010 SHALL have rd_idx  in  clog2(N_OBJ); rd_pos_x/rd_pos_y  out  POS_W; rd_rem_x/rd_rem_y/rd_spd_x/rd_spd_y  out  FX_W; rd_hit  out  2 ({y,x} clamp flags); combinational read.
REQ-011 SHALL have busy  out  1, done  out  1 (one-cycle pulse), ovr  out  1 (sticky overrun), ovr_clr  in  1.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; busy = (state != IDLE).
REQ-013 IDLE: step high at a clock edge SHALL enter RUN with idx=0.
REQ-014 RUN: each edge SHALL update object idx and increment idx; the edge processing idx=N_OBJ-1 SHALL enter DONE.
REQ-015 DONE: done SHALL be high for exactly that cycle; next edge returns to IDLE; step-to-done latency = N_OBJ+1 edges.
REQ-016 Per axis update SHALL be: r = rem + spd; amt = (r + 0x8000) >>> 16 (floor(r+0.5)); rem' = r - (amt << 16); p = pos + amt computed at POS_W+FX_W-16+1 bits.
REQ-017 If p < MIN or p > MAX on an axis, SHALL set pos=bound, rem=0, spd=0 for that axis, and set that axis hit bit; else pos=p, rem=rem', hit bit cleared.
REQ-018 Both axes of one object SHALL update in the same cycle, independently.
REQ-019 Unprocessed objects SHALL retain state in RUN.
REQ-020 wr_ack SHALL equal wr_en && state==IDLE; accepted write SHALL set pos/spd to inputs, rem=0, hit=0 at that edge.
REQ-021 wr_en while busy SHALL be ignored with wr_ack=0 and no state change.
REQ-022 step and wr_en in same IDLE cycle: write SHALL apply at that edge; the pass SHALL use written values.
REQ-023 step high while busy SHALL be ignored (no queued pass) and SHALL set ovr; ovr_clr clears ovr; simultaneous set and clear: set wins.
REQ-024 Spd not modified by pass except REQ-017 clamp.
REQ-025 wr_idx/rd_idx >= N_OBJ: write ignored (wr_ack=0), read returns zeros.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, idx=0, done=0, ovr=0, busy=0.
REQ-027 rst SHALL set every object pos=(RST_X,RST_Y), rem=0, spd=0, hit=0.
REQ-028 rst asserted mid-RUN SHALL abort the pass; no done pulse follows.

Verification
REQ-029 Object 0 at (8,96), spd_x=0x00018000: step -> pos_x=10, rem_x=0xFFFF8000; step again -> pos_x=11, rem_x=0; done exactly N_OBJ+1 cycles after each step.
REQ-030 spd_y=0xFFFF8000 from rem 0: step -> pos_y=96, rem_y=0xFFFF8000; step -> pos_y=95, rem_y=0.
REQ-031 Write pos_x=126, spd_x=0x00030000: step -> pos_x=127, rem_x=0, spd_x=0, rd_hit=2'b01; then spd_x=-1.0 write+step -> pos_x=126, rd_hit=0.
REQ-032 step held high 3 cycles with N_OBJ=4: one pass only, ovr=1, one done pulse; ovr_clr -> ovr=0.
REQ-033 wr_en during RUN -> wr_ack=0, object unchanged; step+wr_en same IDLE cycle -> pass uses written values.
REQ-034 rst asserted at RUN idx=2 -> all objects (8,96), rem=0, spd=0, busy=0 immediately, no done.
